// File: rtl/calc_fixed_fsm.sv
// Fixed-point keypad calculator: multi-digit signed operands, +,-,*,/ with chaining,
// sticky overflow/divide-by-zero flag and a one-bit-per-cycle restoring divider.
module calc_fixed_fsm #(
  parameter int WIDTH      = 16,
  parameter int FRAC       = 4,
  parameter int MAX_DIGITS = 3
) (
  input  logic             i_clk,
  input  logic             i_clear,
  input  logic             i_key_valid,
  input  logic [9:0]       i_button,
  output logic             o_ready,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_entry,
  output logic [WIDTH-1:0] o_result,
  output logic             o_result_valid,
  output logic             o_error,
  output logic [2:0]       o_state
);

  localparam int DW = WIDTH + FRAC;
  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int QW = $clog2(DW + 1);
  localparam logic [DW-1:0] Q_MAX_POS = DW'((64'd1 << (WIDTH - 1)) - 64'd1);
  localparam logic [DW-1:0] Q_MAX_NEG = Q_MAX_POS + DW'(1);

  if ((10 ** MAX_DIGITS) - 1 >= (1 << (WIDTH - 1 - FRAC))) begin : g_param_check
    $error("MAX_DIGITS decimal digits do not fit in the integer part of WIDTH/FRAC");
  end

  typedef enum logic [2:0] {
    S_ENTER_A = 3'd0,
    S_ENTER_B = 3'd1,
    S_EXEC    = 3'd2,
    S_DONE    = 3'd3,
    S_ERROR   = 3'd4
  } state_t;

  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

  state_t           r_state, w_state_nxt;
  op_t              r_op, r_exec_op, w_op;
  logic             r_chain;
  logic [WIDTH-1:0] r_a, r_b, r_result;
  logic [CW-1:0]    r_a_cnt, r_b_cnt;
  logic             r_result_valid, r_error;
  logic [DW-1:0]    r_dvd;
  logic [WIDTH-1:0] r_rem, r_dvs;
  logic             r_neg;
  logic [QW-1:0]    r_div_cnt;

  logic             w_key, w_is_digit, w_is_op, w_is_eq, w_is_sclr;
  logic             w_dig, w_opk, w_eqk, w_clr;
  logic [3:0]       w_digit;
  logic [WIDTH:0]   w_sum;
  logic [2*WIDTH-1:0] w_mul;
  logic [WIDTH-1:0] w_val, w_a_abs, w_b_abs, w_rem_nxt;
  logic             w_ovf, w_exec_done, w_ge;
  logic [WIDTH:0]   w_shift;

  function automatic logic [WIDTH-1:0] push_digit(input logic [WIDTH-1:0] v,
                                                  input logic [3:0] d);
    return (((v >> FRAC) * WIDTH'(10)) + WIDTH'(d)) << FRAC;
  endfunction

  // Handshake: a key is taken on a rising edge where i_key_valid && o_ready;
  // there is no backpressure queue, so keys offered while o_ready=0 are lost.
  assign w_key = i_key_valid && (r_state != S_EXEC);

  always_comb begin
    w_is_digit = 1'b0;
    w_digit    = 4'd0;
    w_is_op    = 1'b0;
    w_op       = OP_ADD;
    for (int d = 0; d < 10; d++) begin
      if (i_button == (10'd1 << d)) begin
        w_is_digit = 1'b1;
        w_digit    = 4'(d);
      end
    end
    case (i_button)
      10'h201: begin w_is_op = 1'b1; w_op = OP_ADD; end
      10'h202: begin w_is_op = 1'b1; w_op = OP_SUB; end
      10'h204: begin w_is_op = 1'b1; w_op = OP_MUL; end
      10'h208: begin w_is_op = 1'b1; w_op = OP_DIV; end
      default: ;
    endcase
  end

  assign w_is_eq   = (i_button == 10'h300);
  assign w_is_sclr = (i_button == 10'h380);
  assign w_dig     = w_key && w_is_digit;
  assign w_opk     = w_key && w_is_op;
  assign w_eqk     = w_key && w_is_eq;
  assign w_clr     = w_key && w_is_sclr;

  assign w_a_abs = r_a[WIDTH-1] ? WIDTH'(0) - r_a : r_a;
  assign w_b_abs = r_b[WIDTH-1] ? WIDTH'(0) - r_b : r_b;
  assign w_mul   = $signed({{WIDTH{r_a[WIDTH-1]}}, r_a} * {{WIDTH{r_b[WIDTH-1]}}, r_b}) >>> FRAC;

  // Restoring divider step: the dividend register shifts left and collects quotient bits.
  assign w_shift   = {r_rem, r_dvd[DW-1]};
  assign w_ge      = (w_shift >= {1'b0, r_dvs});
  assign w_rem_nxt = w_ge ? WIDTH'(w_shift - {1'b0, r_dvs}) : w_shift[WIDTH-1:0];

  assign w_exec_done = (r_exec_op != OP_DIV) || (r_div_cnt == QW'(DW));

  always_comb begin
    w_sum = '0;
    w_val = '0;
    w_ovf = 1'b0;
    case (r_exec_op)
      OP_ADD: begin
        w_sum = {r_a[WIDTH-1], r_a} + {r_b[WIDTH-1], r_b};
        w_val = w_sum[WIDTH-1:0];
        w_ovf = w_sum[WIDTH] ^ w_sum[WIDTH-1];
      end
      OP_SUB: begin
        w_sum = {r_a[WIDTH-1], r_a} - {r_b[WIDTH-1], r_b};
        w_val = w_sum[WIDTH-1:0];
        w_ovf = w_sum[WIDTH] ^ w_sum[WIDTH-1];
      end
      OP_MUL: begin
        w_val = w_mul[WIDTH-1:0];
        w_ovf = !((&w_mul[2*WIDTH-1:WIDTH-1]) || !(|w_mul[2*WIDTH-1:WIDTH-1]));
      end
      OP_DIV: begin
        w_val = r_neg ? WIDTH'(0) - r_dvd[WIDTH-1:0] : r_dvd[WIDTH-1:0];
        w_ovf = (r_dvs == '0) || (r_neg ? (r_dvd > Q_MAX_NEG) : (r_dvd > Q_MAX_POS));
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_clear) begin
    if (i_clear) r_state <= S_ENTER_A;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_ENTER_A: begin
        if (w_opk)      w_state_nxt = S_ENTER_B;
        else if (w_eqk) w_state_nxt = S_DONE;
      end
      S_ENTER_B: if ((w_opk || w_eqk) && (r_b_cnt != '0)) w_state_nxt = S_EXEC;
      S_EXEC: begin
        if (w_exec_done) begin
          if (w_ovf)        w_state_nxt = S_ERROR;
          else if (r_chain) w_state_nxt = S_ENTER_B;
          else              w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (w_dig)      w_state_nxt = S_ENTER_A;
        else if (w_opk) w_state_nxt = S_ENTER_B;
      end
      S_ERROR: ;
      default: w_state_nxt = S_ENTER_A;
    endcase
    if (w_clr) w_state_nxt = S_ENTER_A;
  end

  always_ff @(posedge i_clk or posedge i_clear) begin
    if (i_clear) begin
      r_op <= OP_ADD; r_exec_op <= OP_ADD; r_chain <= 1'b0;
      r_a <= '0; r_b <= '0; r_result <= '0; r_a_cnt <= '0; r_b_cnt <= '0;
      r_result_valid <= 1'b0; r_error <= 1'b0;
      r_dvd <= '0; r_rem <= '0; r_dvs <= '0; r_neg <= 1'b0; r_div_cnt <= '0;
    end else if (w_clr) begin
      r_op <= OP_ADD; r_exec_op <= OP_ADD; r_chain <= 1'b0;
      r_a <= '0; r_b <= '0; r_result <= '0; r_a_cnt <= '0; r_b_cnt <= '0;
      r_result_valid <= 1'b0; r_error <= 1'b0;
      r_dvd <= '0; r_rem <= '0; r_dvs <= '0; r_neg <= 1'b0; r_div_cnt <= '0;
    end else begin
      r_result_valid <= 1'b0;
      case (r_state)
        S_ENTER_A: begin
          if (w_dig) begin
            if (r_a_cnt < CW'(MAX_DIGITS)) begin
              r_a     <= push_digit(r_a, w_digit);
              r_a_cnt <= r_a_cnt + CW'(1);
            end
          end else if (w_opk) begin
            r_op    <= w_op;
            r_b     <= '0;
            r_b_cnt <= '0;
          end else if (w_eqk) begin
            r_result       <= r_a;
            r_result_valid <= 1'b1;
          end
        end
        S_ENTER_B: begin
          if (w_dig) begin
            if (r_b_cnt < CW'(MAX_DIGITS)) begin
              r_b     <= push_digit(r_b, w_digit);
              r_b_cnt <= r_b_cnt + CW'(1);
            end
          end else if (w_opk && (r_b_cnt == '0)) begin
            r_op <= w_op;
          end else if ((w_opk || w_eqk) && (r_b_cnt != '0)) begin
            r_exec_op <= r_op;
            r_chain   <= w_opk;
            if (w_opk) r_op <= w_op;
            r_rem     <= '0;
            r_dvd     <= DW'(w_a_abs) << FRAC;
            r_dvs     <= w_b_abs;
            r_neg     <= r_a[WIDTH-1] ^ r_b[WIDTH-1];
            r_div_cnt <= '0;
          end
        end
        S_EXEC: begin
          if (!w_exec_done) begin
            r_rem     <= w_rem_nxt;
            r_dvd     <= {r_dvd[DW-2:0], w_ge};
            r_div_cnt <= r_div_cnt + QW'(1);
          end else if (w_ovf) begin
            r_result <= '0;
            r_error  <= 1'b1;
          end else begin
            r_result       <= w_val;
            r_result_valid <= 1'b1;
            r_a            <= w_val;
            if (r_chain) begin
              r_b     <= '0;
              r_b_cnt <= '0;
            end
          end
        end
        S_DONE: begin
          if (w_dig) begin
            r_a     <= WIDTH'(w_digit) << FRAC;
            r_a_cnt <= CW'(1);
          end else if (w_opk) begin
            r_op    <= w_op;
            r_a     <= r_result;
            r_b     <= '0;
            r_b_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_ready        = (r_state != S_EXEC);
  assign o_busy         = (r_state == S_EXEC);
  assign o_entry        = (r_state == S_ENTER_A) ? r_a :
                          (r_state == S_ENTER_B) ? r_b : '0;
  assign o_result       = r_result;
  assign o_result_valid = r_result_valid;
  assign o_error        = r_error;
  assign o_state        = r_state;

endmodule

// File: tb/tb_calc_fixed_fsm.sv
// Directed bench for calc_fixed_fsm: keys typed from strings, expected results queued
// at issue time and popped by an independent monitor on each result/error event.
module tb_calc_fixed_fsm;

  localparam int WIDTH = 16;
  localparam int EW    = WIDTH + 1;
  localparam logic [9:0] K_EQ  = 10'h300;
  localparam logic [9:0] K_CLR = 10'h380;

  logic             i_clk = 1'b0;
  logic             i_clear;
  logic             i_key_valid;
  logic [9:0]       i_button;
  logic             o_ready, o_busy, o_result_valid, o_error;
  logic [WIDTH-1:0] o_entry, o_result;
  logic [2:0]       o_state;

  int n_checks = 0;
  int n_pass   = 0;
  int n_cyc;
  logic [EW-1:0] exp_q[$];
  logic          prev_error = 1'b0;

  calc_fixed_fsm #(.WIDTH(16), .FRAC(4), .MAX_DIGITS(3)) dut (
    .i_clk(i_clk), .i_clear(i_clear), .i_key_valid(i_key_valid), .i_button(i_button),
    .o_ready(o_ready), .o_busy(o_busy), .o_entry(o_entry), .o_result(o_result),
    .o_result_valid(o_result_valid), .o_error(o_error), .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Expected entry: {error, result}; error entries carry result 0.
  task automatic expect_result(input logic [WIDTH-1:0] v);
    exp_q.push_back({1'b0, v});
  endtask

  task automatic expect_error();
    exp_q.push_back({1'b1, {WIDTH{1'b0}}});
  endtask

  function automatic logic [9:0] code_of(input byte c);
    if (c >= "0" && c <= "9") return 10'd1 << (c - "0");
    case (c)
      "+": return 10'h201;
      "-": return 10'h202;
      "*": return 10'h204;
      "/": return 10'h208;
      "=": return K_EQ;
      "C": return K_CLR;
      default: return 10'h000;
    endcase
  endfunction

  task automatic press(input logic [9:0] code);
    int n = 0;
    @(negedge i_clk);
    while (!o_ready && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_ready) check("ready_timeout", 32'(o_ready), 32'd1);
    i_key_valid = 1'b1;
    i_button    = code;
    @(negedge i_clk);
    i_key_valid = 1'b0;
    i_button    = 10'h000;
  endtask

  task automatic type_keys(input string s);
    for (int i = 0; i < s.len(); i++) press(code_of(s[i]));
  endtask

  // Monitor: every result_valid pulse or rising error consumes one expectation.
  always @(negedge i_clk) begin
    if (i_clear) begin
      prev_error = 1'b0;
    end else begin
      if (o_result_valid || (o_error && !prev_error)) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_output: got error=%0b result=0x%0h, expected no output",
                   o_error, o_result);
        end else begin
          check("result", 32'({o_error, o_result}), 32'(exp_q.pop_front()));
        end
      end
      prev_error = o_error;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    i_clear = 1'b1; i_key_valid = 1'b0; i_button = 10'h000;
    repeat (2) @(negedge i_clk);
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_entry", 32'(o_entry), 32'd0);
    check("rst_result", 32'(o_result), 32'd0);
    check("rst_result_valid", 32'(o_result_valid), 32'd0);
    check("rst_error", 32'(o_error), 32'd0);
    i_clear = 1'b0;

    // Add 12 + 7 = 19.0
    type_keys("12");
    check("entry_a_12", 32'(o_entry), 32'h00C0);
    type_keys("+7");
    check("entry_b_7", 32'(o_entry), 32'h0070);
    expect_result(16'h0130);
    press(K_EQ);
    check("add_busy", 32'(o_busy), 32'd1);
    check("add_ready_low", 32'(o_ready), 32'd0);
    @(negedge i_clk);
    check("add_busy_done", 32'(o_busy), 32'd0);
    check("add_ready_back", 32'(o_ready), 32'd1);
    check("add_error", 32'(o_error), 32'd0);
    check("done_entry", 32'(o_entry), 32'd0);
    press(K_EQ);

    // Subtract 5 - 9 = -4.0, then chain from DONE: /3 -> -1.3125, *2 -> -2.625
    type_keys("5");
    check("entry_a_5", 32'(o_entry), 32'h0050);
    type_keys("-9");
    expect_result(16'hFFC0);
    press(K_EQ);
    type_keys("/3");
    expect_result(16'hFFEB);
    press(K_EQ);
    type_keys("*2");
    expect_result(16'hFFD6);
    press(K_EQ);

    // Multiply 12*12 = 144.0, then 100*100 overflows
    type_keys("C12*12");
    expect_result(16'h0900);
    press(K_EQ);
    type_keys("100*100");
    expect_error();
    press(K_EQ);
    type_keys("5+3=");
    check("err_sticky", 32'(o_error), 32'd1);
    check("err_result", 32'(o_result), 32'd0);
    check("err_entry", 32'(o_entry), 32'd0);
    type_keys("C");
    check("sclr_error", 32'(o_error), 32'd0);
    check("sclr_result", 32'(o_result), 32'd0);
    check("sclr_ready", 32'(o_ready), 32'd1);

    // Divide 7/2 = 3.5; a soft-clear key offered mid-EXEC must be dropped
    type_keys("7/2");
    expect_result(16'h0038);
    press(K_EQ);
    n_cyc = 0;
    while (o_busy && n_cyc < 100) begin
      if (n_cyc == 3) begin i_key_valid = 1'b1; i_button = K_CLR; end
      if (n_cyc == 5) begin i_key_valid = 1'b0; i_button = 10'h000; end
      n_cyc++;
      @(negedge i_clk);
    end
    i_key_valid = 1'b0; i_button = 10'h000;
    check("div_busy_cycles", 32'(n_cyc), 32'd21);

    // Divide by zero
    type_keys("5/0");
    expect_error();
    press(K_EQ);
    type_keys("C");

    // Chaining: 2+3 -> 5.0 (intermediate), *4 -> 20.0
    type_keys("2+3");
    expect_result(16'h0050);
    press(code_of("*"));
    type_keys("4");
    check("chain_entry_b", 32'(o_entry), 32'h0040);
    expect_result(16'h0140);
    press(K_EQ);

    // Digit limit: fourth digit ignored
    type_keys("1234");
    check("digit_limit", 32'(o_entry), 32'h07B0);

    // Reset during cycle 10 of a divide
    type_keys("/4");
    press(K_EQ);
    repeat (9) @(negedge i_clk);
    check("middiv_busy", 32'(o_busy), 32'd1);
    #2 i_clear = 1'b1;
    #1;
    check("middiv_result", 32'(o_result), 32'd0);
    check("middiv_ready", 32'(o_ready), 32'd1);
    check("middiv_busy_off", 32'(o_busy), 32'd0);
    check("middiv_rv", 32'(o_result_valid), 32'd0);
    check("middiv_entry", 32'(o_entry), 32'd0);
    @(negedge i_clk);
    i_clear = 1'b0;
    repeat (30) @(negedge i_clk);
    check("middiv_no_result", 32'(o_result), 32'd0);

    // '=' in ENTER_A publishes A
    type_keys("42");
    expect_result(16'h02A0);
    press(K_EQ);

    // Operator replacement and '=' with no B digits
    type_keys("C8+-3");
    expect_result(16'h0050);
    press(K_EQ);
    type_keys("C8*=/2");
    expect_result(16'h0040);
    press(K_EQ);

    n_cyc = 0;
    while (exp_q.size() != 0 && n_cyc < 200) begin
      @(negedge i_clk);
      n_cyc++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge i_clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
